// File: rtl/tft_fb_pkg.sv
// Shared framebuffer definitions: RAM geometry and the read-response routing tag.
package tft_fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } rsp_tag_t;

endpackage : tft_fb_pkg

// File: rtl/tft_fb_port_arbiter_if.sv
// Bundle of the DISP/HOST requester handshakes and the framebuffer RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface tft_fb_port_arbiter_if
  import tft_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface : tft_fb_port_arbiter_if

// File: rtl/tft_fb_port_arbiter.sv
// Fixed-priority (DISP first) arbiter for one framebuffer RAM port, with a HOST
// starvation guard and a one-deep response tag that steers read data to its requester.
module tft_fb_port_arbiter
  import tft_fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int MAX_STARVE = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tft_fb_port_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STARVE);

  rsp_tag_t          rsp_tag_reg,     rsp_tag_next;
  logic [7:0]        starve_cnt_reg,  starve_cnt_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic [DATA_W-1:0] disp_rdata_reg;
  logic [DATA_W-1:0] host_rdata_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_tag_reg    <= TAG_NONE;
      starve_cnt_reg <= 8'd0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      disp_rdata_reg <= '0;
      host_rdata_reg <= '0;
    end else begin
      rsp_tag_reg    <= rsp_tag_next;
      starve_cnt_reg <= starve_cnt_next;
      addr_hold_reg  <= bus.mem_address;
      wdata_hold_reg <= bus.mem_writedata;
      disp_rdata_reg <= bus.disp_rdata;
      host_rdata_reg <= bus.host_rdata;
    end
  end

  always_comb begin
    bus.disp_gnt    = 1'b0;
    bus.host_gnt    = 1'b0;
    starve_cnt_next = starve_cnt_reg;
    rsp_tag_next    = TAG_NONE;

    // Grants are masked while reset is asserted so the RAM port stays idle.
    if (reset_n) begin
      if ((starve_cnt_reg == MAX_CNT) && bus.host_req) begin
        bus.host_gnt    = 1'b1;
        starve_cnt_next = 8'd0;
      end else if (bus.disp_req) begin
        bus.disp_gnt = 1'b1;
        if (bus.host_req)
          starve_cnt_next = (starve_cnt_reg == MAX_CNT) ? MAX_CNT : starve_cnt_reg + 8'd1;
        else
          starve_cnt_next = 8'd0;
      end else if (bus.host_req) begin
        bus.host_gnt    = 1'b1;
        starve_cnt_next = 8'd0;
      end
    end

    if (bus.disp_gnt)
      rsp_tag_next = TAG_DISP;
    else if (bus.host_gnt && !bus.host_we)
      rsp_tag_next = TAG_HOST;

    bus.mem_chipselect = bus.disp_gnt | bus.host_gnt;
    bus.mem_write      = bus.host_gnt & bus.host_we;
    bus.mem_clken      = reset_n;
    bus.mem_address    = bus.disp_gnt ? bus.disp_addr :
                         bus.host_gnt ? bus.host_addr : addr_hold_reg;
    bus.mem_writedata  = bus.mem_chipselect ? bus.host_wdata : wdata_hold_reg;

    // RAM q is unregistered, so the tag captured at the grant edge selects the reader now.
    bus.disp_rvalid = (rsp_tag_reg == TAG_DISP);
    bus.host_rvalid = (rsp_tag_reg == TAG_HOST);
    bus.disp_rdata  = bus.disp_rvalid ? bus.mem_readdata : disp_rdata_reg;
    bus.host_rdata  = bus.host_rvalid ? bus.mem_readdata : host_rdata_reg;
  end

endmodule : tft_fb_port_arbiter

// File: tb/tb_tft_fb_port_arbiter.sv
// Bench for tft_fb_port_arbiter: behavioural 64K x 8 RAM, read-data scoreboards per requester.
module tb_tft_fb_port_arbiter;
  import tft_fb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tft_fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  tft_fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM: registered address, combinational q, plus a bench-only preload port.
  logic [DW-1:0] ram [0:65535];
  logic [AW-1:0] ram_addr_q;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write)
        ram[bus.mem_address] <= bus.mem_writedata;
      ram_addr_q <= bus.mem_address;
    end
  end
  assign bus.mem_readdata = ram[ram_addr_q];

  logic [DW-1:0] shadow [0:65535];
  logic [DW-1:0] disp_q [$];
  logic [DW-1:0] host_q [$];
  int tests = 0;
  int fails = 0;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic clk_drive();
    @(posedge clk); #1;
  endtask

  // Sample point: mid-cycle. Any rvalid is matched against the scoreboard queues.
  task automatic clk_sample();
    logic [DW-1:0] exp_d;
    @(negedge clk);
    if (bus.disp_rvalid === 1'b1) begin
      tests++;
      if (disp_q.size() == 0) begin
        fails++;
        $display("FAIL disp_rsp: got unexpected rvalid data %h, required no response", bus.disp_rdata);
      end else begin
        exp_d = disp_q.pop_front();
        if (bus.disp_rdata !== exp_d) begin
          fails++;
          $display("FAIL disp_rsp: got %h, required %h", bus.disp_rdata, exp_d);
        end else
          $display("[TB] t=%0t disp rsp data %h", $time, bus.disp_rdata);
      end
    end
    if (bus.host_rvalid === 1'b1) begin
      tests++;
      if (host_q.size() == 0) begin
        fails++;
        $display("FAIL host_rsp: got unexpected rvalid data %h, required no response", bus.host_rdata);
      end else begin
        exp_d = host_q.pop_front();
        if (bus.host_rdata !== exp_d) begin
          fails++;
          $display("FAIL host_rsp: got %h, required %h", bus.host_rdata, exp_d);
        end else
          $display("[TB] t=%0t host rsp data %h", $time, bus.host_rdata);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0100;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0200; bus.host_wdata = 8'h77;
    clk_sample();
    tests++;
    if ({bus.disp_gnt, bus.host_gnt, bus.mem_chipselect, bus.mem_clken} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got gnt/cs/clken %b, required 0000",
               {bus.disp_gnt, bus.host_gnt, bus.mem_chipselect, bus.mem_clken});
    end
    tests++;
    if ({bus.disp_rvalid, bus.host_rvalid, bus.disp_rdata, bus.host_rdata, bus.mem_address,
         bus.mem_write, bus.mem_writedata} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rv %b%b rd %h/%h addr %h we %b wd %h, required all 0",
               bus.disp_rvalid, bus.host_rvalid, bus.disp_rdata, bus.host_rdata,
               bus.mem_address, bus.mem_write, bus.mem_writedata);
    end
    $display("[TB] t=%0t reset held with both requests", $time);
    clk_drive();
    reset_n = 1'b1;
    clk_sample();
    tests++;
    if ({bus.disp_gnt, bus.host_gnt, bus.mem_clken} !== 3'b101) begin
      fails++;
      $display("FAIL reset_first_gnt: got disp/host/clken %b, required 101",
               {bus.disp_gnt, bus.host_gnt, bus.mem_clken});
    end
    disp_q.push_back(shadow[16'h0100]);
    clk_drive();
    bus.disp_req = 1'b0; bus.host_req = 1'b0;
    clk_sample();
    tests++;
    if (bus.disp_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_rsp: got disp_rvalid %b, required 1", bus.disp_rvalid);
    end
    tests++;
    if ({bus.mem_chipselect, bus.mem_address} !== {1'b0, 16'h0100}) begin
      fails++;
      $display("FAIL idle_hold: got cs %b addr %h, required cs 0 addr 0100",
               bus.mem_chipselect, bus.mem_address);
    end
    clk_drive();
  endtask

  task automatic test_host_write_read();
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h1234; bus.host_wdata = 8'hA5;
    clk_sample();
    tests++;
    if ({bus.host_gnt, bus.mem_write, bus.mem_address, bus.mem_writedata} !== {2'b11, 16'h1234, 8'hA5}) begin
      fails++;
      $display("FAIL host_wr_bus: got gnt %b we %b addr %h wd %h, required 1 1 1234 a5",
               bus.host_gnt, bus.mem_write, bus.mem_address, bus.mem_writedata);
    end
    shadow[16'h1234] = 8'hA5;
    $display("[TB] t=%0t host write 1234 <= a5", $time);
    clk_drive();
    bus.host_req = 1'b0;
    clk_sample();
    tests++;
    if (bus.host_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL host_wr_norsp: got host_rvalid %b, required 0", bus.host_rvalid);
    end
    clk_drive();
    bus.host_req = 1'b1; bus.host_we = 1'b0;
    clk_sample();
    tests++;
    if ({bus.host_gnt, bus.mem_write} !== 2'b10) begin
      fails++;
      $display("FAIL host_rd_gnt: got gnt/we %b, required 10", {bus.host_gnt, bus.mem_write});
    end
    host_q.push_back(shadow[16'h1234]);
    clk_drive();
    bus.host_req = 1'b0;
    clk_sample();
    tests++;
    if ({bus.host_rvalid, bus.disp_rvalid} !== 2'b10) begin
      fails++;
      $display("FAIL host_rd_rsp: got host/disp rvalid %b, required 10", {bus.host_rvalid, bus.disp_rvalid});
    end
    clk_drive();
    clk_sample();
    tests++;
    if (bus.host_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL host_rd_pulse: got host_rvalid %b, required 0", bus.host_rvalid);
    end
    clk_drive();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0100;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0200;
    for (int i = 1; i <= 18; i++) begin
      clk_sample();
      exp_g = (i % 9 == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({bus.disp_gnt, bus.host_gnt} !== exp_g) begin
        fails++;
        $display("FAIL starve_cycle%0d: got disp/host gnt %b, required %b", i, {bus.disp_gnt, bus.host_gnt}, exp_g);
      end else
        $display("[TB] t=%0t starve cycle %0d gnt %b", $time, i, exp_g);
      if (exp_g[1]) disp_q.push_back(shadow[16'h0100]);
      else          host_q.push_back(shadow[16'h0200]);
      clk_drive();
    end
    bus.disp_req = 1'b0; bus.host_req = 1'b0;
    clk_sample();
    clk_drive();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      bus.disp_req  = (i < 4);
      bus.disp_addr = 16'(i < 4 ? i : 3);
      clk_sample();
      if (i < 4) begin
        tests++;
        if (bus.disp_gnt !== 1'b1) begin
          fails++;
          $display("FAIL b2b_gnt%0d: got disp_gnt %b, required 1", i, bus.disp_gnt);
        end
        disp_q.push_back(shadow[16'(i)]);
      end
      if (i >= 1) begin
        tests++;
        if (bus.disp_rvalid !== (i <= 4)) begin
          fails++;
          $display("FAIL b2b_rvalid%0d: got disp_rvalid %b, required %b", i, bus.disp_rvalid, (i <= 4));
        end
      end
      clk_drive();
    end
  endtask

  task automatic test_interleave();
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0300;
    clk_sample();
    tests++;
    if (bus.disp_gnt !== 1'b1) begin
      fails++;
      $display("FAIL ilv_disp_gnt: got %b, required 1", bus.disp_gnt);
    end
    disp_q.push_back(shadow[16'h0300]);
    clk_drive();
    bus.disp_req = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0400;
    clk_sample();
    tests++;
    if ({bus.host_gnt, bus.disp_rvalid, bus.host_rvalid} !== 3'b110) begin
      fails++;
      $display("FAIL ilv_n1: got host_gnt/disp_rv/host_rv %b, required 110",
               {bus.host_gnt, bus.disp_rvalid, bus.host_rvalid});
    end
    host_q.push_back(shadow[16'h0400]);
    clk_drive();
    bus.host_req = 1'b0;
    clk_sample();
    tests++;
    if ({bus.disp_rvalid, bus.host_rvalid} !== 2'b01) begin
      fails++;
      $display("FAIL ilv_n2: got disp_rv/host_rv %b, required 01", {bus.disp_rvalid, bus.host_rvalid});
    end
    clk_drive();
  endtask

  task automatic test_async_reset();
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0101;
    clk_sample();
    tests++;
    if (bus.disp_gnt !== 1'b1) begin
      fails++;
      $display("FAIL arst_gnt: got %b, required 1", bus.disp_gnt);
    end
    disp_q.push_back(shadow[16'h0101]);
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.disp_req = 1'b0;
    #1;
    tests++;
    if ({bus.disp_rvalid, bus.host_rvalid, bus.disp_rdata, bus.host_rdata, bus.mem_chipselect,
         bus.mem_clken, bus.mem_address, bus.mem_write, bus.mem_writedata} !== '0) begin
      fails++;
      $display("FAIL arst_outputs: got rv %b%b rd %h/%h cs %b clken %b addr %h, required all 0",
               bus.disp_rvalid, bus.host_rvalid, bus.disp_rdata, bus.host_rdata,
               bus.mem_chipselect, bus.mem_clken, bus.mem_address);
    end
    $display("[TB] t=%0t async reset mid-read, outstanding read dropped", $time);
    disp_q.delete();
    host_q.delete();
    clk_sample();
    clk_drive();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_sample();
      tests++;
      if (bus.disp_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL arst_norsp%0d: got disp_rvalid %b, required 0", i, bus.disp_rvalid);
      end
      clk_drive();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    preload(16'h0100, 8'h5C);
    preload(16'h0200, 8'hE7);
    preload(16'h0101, 8'h99);
    preload(16'h0300, 8'h3C);
    preload(16'h0400, 8'hC3);
    for (int i = 0; i < 4; i++) preload(16'(i), 8'(8'h10 + i));

    test_reset();
    test_host_write_read();
    test_starvation();
    test_back_to_back();
    test_interleave();
    test_async_reset();

    tests++;
    if (disp_q.size() != 0 || host_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d disp / %0d host responses outstanding, required 0/0",
               disp_q.size(), host_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_tft_fb_port_arbiter
